button_press_classifier: RTL and testbench
==========================================

Name: button_press_classifier

Overview:
- Sits directly downstream of the debouncer. Consumes its clean, clk-synchronous debounced_signal bus and turns each level into single-cycle event pulses: press, short press, long press, auto-repeat and release.
- Feeds user-input logic such as counters and FSMs, which need one-cycle strobes rather than levels.
- Channels are fully independent, one per input bit.

Parameters:
- WIDTH, 1: number of independent button channels.
- LONG_CNT, 8: number of consecutive high samples that make a long press. Must be >= 2.
- REPEAT_CNT, 4: high samples between auto-repeat pulses after a long press. 0 disables auto-repeat.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- debounced_signal  input  WIDTH  debounced button levels, synchronous to clk (debouncer output).
- press_pulse  output  WIDTH  1-cycle strobe on press.
- release_pulse  output  WIDTH  1-cycle strobe on release.
- short_press  output  WIDTH  1-cycle strobe on a release before long-press threshold.
- long_press  output  WIDTH  1-cycle strobe when hold reaches LONG_CNT samples.
- repeat_pulse  output  WIDTH  1-cycle strobe every REPEAT_CNT samples while long-held.

Behaviour:
- Per channel i:
  - prev[i] register; rise = sig & ~prev; fall = ~sig & prev.
  - 3-state FSM: IDLE, HELD, LONG.
  - hold_cnt, width $clog2(LONG_CNT+1).
  - rep_cnt, width $clog2(REPEAT_CNT+1), minimum 1 bit.
- All outputs are registered. A strobe is high for exactly the one cycle following the posedge that decided it, and is 0 in every other cycle.
- Reset (async, immediate): all outputs 0, FSM IDLE, counters 0, prev = all ones. Consequence: an input already high when reset deasserts produces no event until it is released and pressed again.
- Let edge k be the posedge at which sig=1 and prev=0.
- IDLE:
  - rise → press_pulse, hold_cnt <= 1, go HELD.
  - Otherwise stay; no strobes.
- HELD:
  - sig=0 → short_press and release_pulse in the same cycle, go IDLE.
  - sig=1 and hold_cnt == LONG_CNT-1 → long_press, rep_cnt <= 0, go LONG. long_press therefore follows edge k+LONG_CNT-1.
  - Otherwise hold_cnt++.
- LONG:
  - sig=0 → release_pulse only (no short_press), go IDLE.
  - sig=1 and REPEAT_CNT != 0 → rep_cnt++. When rep_cnt == REPEAT_CNT-1: repeat_pulse, rep_cnt <= 0.
  - Repeats follow edges k+LONG_CNT-1+n*REPEAT_CNT, n >= 1, for as long as the input is held.
  - REPEAT_CNT == 0: no repeats; hold indefinitely.
- Counters never wrap. hold_cnt stops at LONG_CNT-1 (HELD exits). rep_cnt is reset on each pulse.
- Simultaneous events on different channels are handled independently in the same cycle; no arbitration.
- A 1-sample press produces press_pulse and, one cycle later, short_press + release_pulse. It is never dropped.
- A new rise in the cycle after a release is a valid new press.
- Reset asserted mid-operation (any state): outputs clear within the same cycle. No release or short strobe is generated for the aborted press.

Test Plan:
All scenarios use WIDTH=2, LONG_CNT=8, REPEAT_CNT=4.
1. Reset, inputs 0 → all outputs 0. Bit0 high for 3 edges (k..k+2), then low → press_pulse[0] after k; short_press[0] and release_pulse[0] after k+3; long_press never asserts.
2. Bit0 high for exactly 7 samples → short_press after k+7, no long_press. High for exactly 8 samples → long_press after k+7; on release, release_pulse only, short_press stays 0.
3. Bit0 held 20 samples → long_press after k+7; repeat_pulse after k+11, k+15, k+19 (exactly 3); release_pulse after k+20. Each strobe is one cycle wide.
4. Both bits rise on the same edge; bit1 released after 2 samples, bit0 held 10 → both press_pulses in the same cycle; bit1 short_press after k+2; bit0 long_press after k+7, no cross-channel interference.
5. Bit0 held into LONG, assert rst for 2 cycles with input still high → outputs 0 immediately; after deassert no press_pulse while high; release then re-press → normal press_pulse.
6. Rerun scenario 3 with REPEAT_CNT=0 → long_press once, zero repeat_pulse over 50 held cycles, release_pulse on release.

Source files
------------

// File: rtl/button_press_classifier.sv
// Per-channel classifier for debounced buttons: turns each level into one-cycle
// press, short-press, long-press, auto-repeat and release strobes.
module button_press_classifier #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned LONG_CNT   = 8,
  parameter int unsigned REPEAT_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] short_press,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] repeat_pulse
);

  localparam int unsigned HOLD_W   = $clog2(LONG_CNT + 1);
  localparam int unsigned REP_RAW  = $clog2(REPEAT_CNT + 1);
  localparam int unsigned REP_W    = (REP_RAW > 0) ? REP_RAW : 1;
  localparam bit          REP_EN   = (REPEAT_CNT != 0);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic              sig;
    state_e            state_q, state_d;
    logic              prev_q, prev_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;

    assign sig = debounced_signal[i];

    // prev resets high so a button already held at reset must be re-pressed
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q    <= ST_IDLE;
        prev_q     <= 1'b1;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        short_q    <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        state_q    <= state_d;
        prev_q     <= prev_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        press_q    <= press_d;
        release_q  <= release_d;
        short_q    <= short_d;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
      end
    end

    always_comb begin
      state_d    = state_q;
      prev_d     = sig;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      short_d    = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (sig && !prev_q) begin
            press_d    = 1'b1;
            hold_cnt_d = HOLD_W'(1);
            state_d    = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!sig) begin
            short_d    = 1'b1;
            release_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_IDLE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            long_d     = 1'b1;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            state_d    = ST_LONG;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (!sig) begin
            release_d = 1'b1;
            rep_cnt_d = '0;
            state_d   = ST_IDLE;
          end else if (REP_EN) begin
            // repeat period restarts on every pulse
            if (rep_cnt_q == REP_LAST) begin
              repeat_d  = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign short_press[i]   = short_q;
    assign long_press[i]    = long_q;
    assign repeat_pulse[i]  = repeat_q;
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: two instances (auto-repeat 4 and disabled)
// share stimulus and are checked every cycle against a hold-length model.
module tb_button_press_classifier;

  localparam int LONG  = 8;
  localparam int REP_A = 4;
  localparam int REP_B = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] debounced_signal;

  logic [1:0] p_a, r_a, s_a, l_a, rp_a;
  logic [1:0] p_b, r_b, s_b, l_b, rp_b;

  always #5 clk = ~clk;

  button_press_classifier #(.WIDTH(2), .LONG_CNT(LONG), .REPEAT_CNT(REP_A)) u_dut_a (
    .clk(clk), .rst(rst), .debounced_signal(debounced_signal),
    .press_pulse(p_a), .release_pulse(r_a), .short_press(s_a),
    .long_press(l_a), .repeat_pulse(rp_a)
  );

  button_press_classifier #(.WIDTH(2), .LONG_CNT(LONG), .REPEAT_CNT(REP_B)) u_dut_b (
    .clk(clk), .rst(rst), .debounced_signal(debounced_signal),
    .press_pulse(p_b), .release_pulse(r_b), .short_press(s_b),
    .long_press(l_b), .repeat_pulse(rp_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // model: per instance/channel, whether a valid press is in progress and its length
  int   rep_per [2];
  bit   active  [2][2];
  bit   prev_m  [2][2];
  int   hold_n  [2][2];
  logic [1:0] e_p [2];
  logic [1:0] e_r [2];
  logic [1:0] e_s [2];
  logic [1:0] e_l [2];
  logic [1:0] e_rp[2];

  int rep_seen_a, rep_seen_b, long_seen_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        active[d][c] = 1'b0;
        prev_m[d][c] = 1'b1;
        hold_n[d][c] = 0;
      end
      e_p[d] = '0; e_r[d] = '0; e_s[d] = '0; e_l[d] = '0; e_rp[d] = '0;
    end
  endtask

  task automatic model_step(input logic [1:0] s);
    for (int d = 0; d < 2; d++) begin
      e_p[d] = '0; e_r[d] = '0; e_s[d] = '0; e_l[d] = '0; e_rp[d] = '0;
      for (int c = 0; c < 2; c++) begin
        if (active[d][c]) begin
          if (s[c]) begin
            hold_n[d][c]++;
            if (hold_n[d][c] == LONG)
              e_l[d][c] = 1'b1;
            else if (hold_n[d][c] > LONG && rep_per[d] != 0 &&
                     ((hold_n[d][c] - LONG) % rep_per[d]) == 0)
              e_rp[d][c] = 1'b1;
          end else begin
            e_r[d][c] = 1'b1;
            if (hold_n[d][c] < LONG) e_s[d][c] = 1'b1;
            active[d][c] = 1'b0;
          end
        end else if (s[c] && !prev_m[d][c]) begin
          active[d][c] = 1'b1;
          hold_n[d][c] = 1;
          e_p[d][c]    = 1'b1;
        end
        prev_m[d][c] = s[c];
      end
    end
  endtask

  task automatic compare_all();
    chk("a press",   32'(p_a),  32'(e_p[0]));
    chk("a release", 32'(r_a),  32'(e_r[0]));
    chk("a short",   32'(s_a),  32'(e_s[0]));
    chk("a long",    32'(l_a),  32'(e_l[0]));
    chk("a repeat",  32'(rp_a), 32'(e_rp[0]));
    chk("b press",   32'(p_b),  32'(e_p[1]));
    chk("b release", 32'(r_b),  32'(e_r[1]));
    chk("b short",   32'(s_b),  32'(e_s[1]));
    chk("b long",    32'(l_b),  32'(e_l[1]));
    chk("b repeat",  32'(rp_b), 32'(e_rp[1]));
  endtask

  task automatic tick(input logic [1:0] s);
    debounced_signal = s;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(s);
    #1;
    compare_all();
    rep_seen_a  += 32'(rp_a[0]);
    rep_seen_b  += 32'(rp_b[0]);
    long_seen_b += 32'(l_b[0]);
  endtask

  task automatic ticks(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) tick(s);
  endtask

  initial begin
    rep_per[0] = REP_A;
    rep_per[1] = REP_B;
    rep_seen_a = 0; rep_seen_b = 0; long_seen_b = 0;
    rst = 1'b1;
    debounced_signal = 2'b00;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    chk("reset outputs", 32'({p_a, r_a, s_a, l_a, rp_a}), 32'h0);
    rst = 1'b0;
    ticks(2'b00, 2);

    // 1: three-sample press
    tick(2'b01);
    chk("s1 press", 32'(p_a), 32'h1);
    ticks(2'b01, 2);
    tick(2'b00);
    chk("s1 short+release", 32'({s_a, r_a}), 32'h5);
    ticks(2'b00, 3);

    // 2: seven samples is short, eight is long
    ticks(2'b01, 7);
    tick(2'b00);
    chk("s2 short at 7", 32'({s_a, l_a}), 32'h4);
    ticks(2'b00, 2);
    ticks(2'b01, 8);
    chk("s2 long at 8", 32'(l_a), 32'h1);
    tick(2'b00);
    chk("s2 release no short", 32'({r_a, s_a}), 32'h4);
    ticks(2'b00, 2);

    // 3: 20-sample hold
    rep_seen_a = 0; rep_seen_b = 0;
    ticks(2'b01, 20);
    tick(2'b00);
    chk("s3 release", 32'(r_a), 32'h1);
    chk("s3 repeat count", 32'(rep_seen_a), 32'd3);
    chk("s3 no repeat when disabled", 32'(rep_seen_b), 32'd0);
    ticks(2'b00, 2);

    // 4: simultaneous rise, bit1 short, bit0 long
    tick(2'b11);
    chk("s4 both press", 32'(p_a), 32'h3);
    tick(2'b11);
    tick(2'b01);
    chk("s4 bit1 short", 32'(s_a), 32'h2);
    ticks(2'b01, 4);
    tick(2'b01);
    chk("s4 bit0 long", 32'(l_a), 32'h1);
    ticks(2'b01, 2);
    tick(2'b00);
    ticks(2'b00, 2);

    // 5: reset while long-held
    ticks(2'b01, 8);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("s5 async clear", 32'({p_a, r_a, s_a, l_a, rp_a}), 32'h0);
    ticks(2'b01, 2);
    rst = 1'b0;
    ticks(2'b01, 4);
    chk("s5 no press while held", 32'(p_a), 32'h0);
    tick(2'b00);
    chk("s5 no release for aborted", 32'(r_a), 32'h0);
    tick(2'b01);
    chk("s5 re-press", 32'(p_a), 32'h1);
    tick(2'b00);
    ticks(2'b00, 2);

    // 6: 50-sample hold, repeats only where enabled
    rep_seen_a = 0; rep_seen_b = 0; long_seen_b = 0;
    ticks(2'b01, 50);
    chk("s6 long once", 32'(long_seen_b), 32'd1);
    chk("s6 zero repeats", 32'(rep_seen_b), 32'd0);
    chk("s6 repeats enabled", 32'(rep_seen_a), 32'd10);
    tick(2'b00);
    chk("s6 release", 32'(r_b), 32'h1);
    ticks(2'b00, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
